dmem_responder: RTL and testbench

//  Data-memory responder for the MEM-stage port of the 5-stage MIPS pipeline.

---
 rtl/dmem_responder_pkg.sv | 13 +
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder_store_buffer.sv | 80 ++++++++
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and default sizes for the MEM-stage data-memory responder.
package dmem_responder_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int RAM_AW_DEF   = 10;

    // Responder FSM: IDLE serves hits, writes and drains; RD_WAIT returns RAM read data.
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU-side and RAM-side buses of the data-memory responder.

// CPU MEM-stage port: master is the CPU, slave is the responder.
interface dmem_responder_cpu_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    modport master (output mem_ren, mem_wen, mem_addr, mem_wdata,
                    input  mem_rdata, mem_stall);
    modport slave  (input  mem_ren, mem_wen, mem_addr, mem_wdata,
                    output mem_rdata, mem_stall);
endinterface

// Shared RAM port behind the arbiter: master is the responder, slave is arbiter/RAM.
interface dmem_responder_ram_if import dmem_responder_pkg::*;
    #(parameter int RAM_AW = RAM_AW_DEF);
    logic              ram_req;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_gnt;
    logic [31:0]       ram_rdata;

    modport master (output ram_req, ram_we, ram_addr, ram_wdata,
                    input  ram_gnt, ram_rdata);
    modport slave  (input  ram_req, ram_we, ram_addr, ram_wdata,
                    output ram_gnt, ram_rdata);
endinterface

// File: rtl/dmem_responder_store_buffer.sv
// FIFO store buffer with a parallel tag search; the youngest matching entry wins.
module dmem_responder_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          waddr,
    input  logic [31:0]            wdata,
    output logic [AW-1:0]          head_addr,
    output logic [31:0]            head_data,
    input  logic [AW-1:0]          search_tag,
    output logic                   hit,
    output logic [31:0]            hit_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] idx;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= waddr;
            data_q[tail] <= wdata;
        end
    end

    // Scan oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (i < int'(count) && addr_q[idx] == search_tag) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign head_addr = addr_q[head];
    assign head_data = data_q[head];

    // Overflow and underflow cannot happen given the top-level push/pop gating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == ($clog2(DEPTH)+1)'(DEPTH)))
                else $error("store buffer push while full");
            assert (!(pop && count == '0))
                else $error("store buffer pop while empty");
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: store buffer with load forwarding, RAM read misses and
// background drains sharing one arbitrated RAM port, and the pipeline stall.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | serve hits and writes, issue read misses, drain when free
//  S_RD_WAIT | granted read returns: forward ram_rdata, port free to drain
module dmem_responder import dmem_responder_pkg::*; #(
    parameter int SB_DEPTH = SB_DEPTH_DEF,
    parameter int RAM_AW   = RAM_AW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    dmem_responder_cpu_if.slave       cpu,
    dmem_responder_ram_if.master      ram,
    output logic                      sb_empty,
    output logic [$clog2(SB_DEPTH):0] sb_count
);

    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    dmem_state_e       state;
    logic [RAM_AW-1:0] tag;
    logic [RAM_AW-1:0] head_addr;
    logic [31:0]       head_data;
    logic [31:0]       hit_data;
    logic              hit;
    logic              in_idle;
    logic              is_rd;
    logic              is_wr;
    logic              rd_miss;
    logic              drain;
    logic              push;
    logic              pop;
    logic              sb_full;
    logic              unused_addr_bits;

    assign tag              = cpu.mem_addr[RAM_AW+1:2];
    assign unused_addr_bits = ^{cpu.mem_addr[31:RAM_AW+2], cpu.mem_addr[1:0]};

    // A simultaneous ren/wen is a write; reads are only evaluated in IDLE.
    assign in_idle = (state == S_IDLE);
    assign is_wr   = cpu.mem_wen;
    assign is_rd   = cpu.mem_ren & ~cpu.mem_wen;
    assign rd_miss = in_idle & is_rd & ~hit;
    assign sb_full = (sb_count == CNT_W'(SB_DEPTH));

    // A read miss owns the port; otherwise any buffered store drains, also in RD_WAIT.
    assign drain = ~rd_miss & (sb_count != '0);
    assign pop   = drain & ram.ram_gnt;
    assign push  = in_idle & is_wr & (~sb_full | pop);

    assign ram.ram_req   = rd_miss | drain;
    assign ram.ram_we    = drain;
    assign ram.ram_addr  = rd_miss ? tag : head_addr;
    assign ram.ram_wdata = head_data;

    assign cpu.mem_stall = in_idle & (rd_miss | (is_wr & ~push));
    assign sb_empty      = (sb_count == '0);

    // Load data: RAM return in RD_WAIT, buffer forward on a hit, zero otherwise.
    always_comb begin
        cpu.mem_rdata = '0;
        if (!in_idle)
            cpu.mem_rdata = ram.ram_rdata;
        else if (is_rd && hit)
            cpu.mem_rdata = hit_data;
    end

    // RD_WAIT lasts exactly one cycle after a granted read miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (rd_miss && ram.ram_gnt) state <= S_RD_WAIT;
                S_RD_WAIT: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    dmem_responder_store_buffer #(
        .DEPTH (SB_DEPTH),
        .AW    (RAM_AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .waddr      (tag),
        .wdata      (cpu.mem_wdata),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .search_tag (tag),
        .hit        (hit),
        .hit_data   (hit_data),
        .count      (sb_count)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// multi-cycle sequences, then random traffic against an architectural memory model.
module tb_dmem_responder;

    localparam int SB_DEPTH = 4;
    localparam int RAM_AW   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sb_empty;
    logic [2:0] sb_count;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    dmem_responder_cpu_if                      cpu_bus ();
    dmem_responder_ram_if #(.RAM_AW(RAM_AW))   ram_bus ();

    dmem_responder #(.SB_DEPTH(SB_DEPTH), .RAM_AW(RAM_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_bus.slave),
        .ram      (ram_bus.master),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    // RAM behind the arbiter: synchronous read, drains logged in arrival order.
    typedef struct packed { logic [9:0] a; logic [31:0] d; } drain_t;
    logic [31:0] ram_mem [1024];
    drain_t      drain_log [$];

    always @(posedge clk) begin
        if (ram_bus.ram_req && ram_bus.ram_gnt) begin
            if (ram_bus.ram_we) begin
                ram_mem[ram_bus.ram_addr] = ram_bus.ram_wdata;
                drain_log.push_back({ram_bus.ram_addr, ram_bus.ram_wdata});
            end else begin
                ram_bus.ram_rdata <= ram_mem[ram_bus.ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] d, input logic g);
        rst               = r;
        cpu_bus.mem_ren   = ren;
        cpu_bus.mem_wen   = wen;
        cpu_bus.mem_addr  = a;
        cpu_bus.mem_wdata = d;
        ram_bus.ram_gnt   = g;
    endtask

    // One cycle: inputs change just after the edge, outputs sampled at the falling edge.
    task automatic step(input logic r, input logic ren, input logic wen,
                        input logic [31:0] a, input logic [31:0] d, input logic g);
        @(posedge clk);
        #1;
        drive(r, ren, wen, a, d, g);
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, ren, wen;
        logic [31:0] a, d;
        logic        g, c;
        logic        stall;
        logic [31:0] rdata;
        logic        req, we;
        logic [2:0]  cnt;
    } vec_t;
    vec_t vq [$];

    task automatic add(input logic r, input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d, input logic g,
                       input logic c, input logic st, input logic [31:0] rd,
                       input logic rq, input logic we, input logic [2:0] n);
        vq.push_back('{r, ren, wen, a, d, g, c, st, rd, rq, we, n});
    endtask

    typedef struct { logic [9:0] tag; logic [31:0] data; } entry_t;
    entry_t      mq [$];
    logic [31:0] arch_mem [1024];

    initial begin
        logic        r_ren, r_wen, g, hold, rd_wait_m, miss, hit, dpos, accept;
        logic [31:0] r_addr, r_data, rd_val, exp_rdata;
        logic        exp_stall;
        logic [9:0]  t;
        int          n, kind;

        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
        ram_mem[10'h10] = 32'h0000_1234;
        ram_mem[10'h11] = 32'h0000_5555;
        ram_mem[10'h12] = 32'h0000_A5A5;
        ram_mem[10'h20] = 32'h0000_CAFE;

        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //   r ren wen addr        wdata          g chk stall rdata          req we cnt
        add(1, 0, 0, 32'h00, 32'h0,           0, 1, 0, 32'h0,           0, 0, 0);
        add(0, 0, 1, 32'h10, 32'hDEADBEEF,    0, 1, 0, 32'h0,           0, 0, 0);
        add(0, 1, 0, 32'h10, 32'h0,           0, 1, 0, 32'hDEADBEEF,    1, 1, 1);
        add(1, 0, 0, 32'h00, 32'h0,           0, 0, 0, 32'h0,           0, 0, 0);
        add(0, 0, 1, 32'h20, 32'h1,           0, 1, 0, 32'h0,           0, 0, 0);
        add(0, 0, 1, 32'h20, 32'h2,           0, 1, 0, 32'h0,           1, 1, 1);
        add(0, 1, 0, 32'h20, 32'h0,           0, 1, 0, 32'h2,           1, 1, 2);
        add(0, 0, 0, 32'h00, 32'h0,           0, 1, 0, 32'h0,           1, 1, 2);
        add(1, 0, 0, 32'h00, 32'h0,           0, 0, 0, 32'h0,           0, 0, 0);
        add(0, 1, 0, 32'h40, 32'h0,           1, 1, 1, 32'h0,           1, 0, 0);
        add(0, 1, 0, 32'h40, 32'h0,           1, 1, 0, 32'h1234,        0, 0, 0);
        add(0, 0, 0, 32'h00, 32'h0,           0, 1, 0, 32'h0,           0, 0, 0);
        add(0, 1, 0, 32'h44, 32'h0,           0, 1, 1, 32'h0,           1, 0, 0);
        add(0, 1, 0, 32'h44, 32'h0,           0, 1, 1, 32'h0,           1, 0, 0);
        add(0, 1, 0, 32'h44, 32'h0,           1, 1, 1, 32'h0,           1, 0, 0);
        add(0, 1, 0, 32'h44, 32'h0,           0, 1, 0, 32'h5555,        0, 0, 0);
        add(0, 1, 1, 32'h44, 32'h7,           0, 1, 0, 32'h0,           0, 0, 0);
        add(0, 1, 1, 32'h44, 32'h9,           0, 1, 0, 32'h0,           1, 1, 1);
        add(0, 1, 0, 32'h48, 32'h0,           0, 1, 1, 32'h0,           1, 0, 2);
        add(0, 1, 0, 32'h48, 32'h0,           1, 1, 1, 32'h0,           1, 0, 2);
        add(0, 1, 0, 32'h48, 32'h0,           1, 1, 0, 32'hA5A5,        1, 1, 2);
        add(0, 0, 0, 32'h00, 32'h0,           0, 1, 0, 32'h0,           1, 1, 1);
        add(0, 1, 0, 32'h44, 32'h0,           0, 1, 0, 32'h9,           1, 1, 1);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].ren, vq[i].wen, vq[i].a, vq[i].d, vq[i].g);
            if (vq[i].c) begin
                chk($sformatf("v%0d stall", i), 32'(cpu_bus.mem_stall), 32'(vq[i].stall));
                chk($sformatf("v%0d rdata", i), cpu_bus.mem_rdata, vq[i].rdata);
                chk($sformatf("v%0d req", i), 32'(ram_bus.ram_req), 32'(vq[i].req));
                chk($sformatf("v%0d we", i), 32'(ram_bus.ram_we), 32'(vq[i].we));
                chk($sformatf("v%0d count", i), 32'(sb_count), 32'(vq[i].cnt));
                chk($sformatf("v%0d empty", i), 32'(sb_empty), 32'(vq[i].cnt == 3'd0));
            end
        end

        // Full buffer: fifth write stalls until a drain frees a slot in the same cycle.
        step(1, 0, 0, 0, 0, 0);
        drain_log.delete();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 32'(i * 4), 32'h100 + 32'(i), 0);
            chk($sformatf("fill%0d stall", i), 32'(cpu_bus.mem_stall), 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 32'h10, 32'h500, 0);
            chk($sformatf("full%0d stall", k), 32'(cpu_bus.mem_stall), 32'h1);
            chk($sformatf("full%0d count", k), 32'(sb_count), 32'h4);
        end
        step(0, 0, 1, 32'h10, 32'h500, 1);
        chk("fullgnt stall", 32'(cpu_bus.mem_stall), 32'h0);
        chk("fullgnt we", 32'(ram_bus.ram_we), 32'h1);
        chk("fullgnt addr", 32'(ram_bus.ram_addr), 32'h0);
        step(0, 0, 0, 0, 0, 1);
        chk("pushpop count", 32'(sb_count), 32'h4);
        n = 0;
        while (!sb_empty && n < 20) begin
            step(0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("drain done", 32'(sb_empty), 32'h1);
        chk("drain len", 32'(drain_log.size()), 32'h5);
        for (int i = 0; i < 5; i++) begin
            if (i < drain_log.size()) begin
                chk($sformatf("drain%0d addr", i), 32'(drain_log[i].a), 32'(i));
                chk($sformatf("drain%0d data", i), drain_log[i].d,
                    (i < 4) ? 32'h100 + 32'(i) : 32'h500);
            end
        end

        // Reset during RD_WAIT abandons the read and empties the buffer.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h84, 32'h77, 0);
        step(0, 1, 0, 32'h80, 32'h0, 1);
        chk("rst6 miss stall", 32'(cpu_bus.mem_stall), 32'h1);
        chk("rst6 miss we", 32'(ram_bus.ram_we), 32'h0);
        chk("rst6 miss addr", 32'(ram_bus.ram_addr), 32'h20);
        chk("rst6 count", 32'(sb_count), 32'h1);
        step(1, 1, 0, 32'h80, 32'h0, 0);
        chk("rst6 rdwait rdata", cpu_bus.mem_rdata, 32'hCAFE);
        step(0, 0, 0, 0, 0, 0);
        chk("rst6 stall", 32'(cpu_bus.mem_stall), 32'h0);
        chk("rst6 rdata", cpu_bus.mem_rdata, 32'h0);
        chk("rst6 count0", 32'(sb_count), 32'h0);
        chk("rst6 empty", 32'(sb_empty), 32'h1);
        chk("rst6 req", 32'(ram_bus.ram_req), 32'h0);

        // Random traffic: loads must see the latest store; stalls follow the port rules.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) arch_mem[i] = ram_mem[i];
        mq.delete();
        hold = 0; rd_wait_m = 0; rd_val = 0;
        r_ren = 0; r_wen = 0; r_addr = 0; r_data = 0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                kind   = $urandom_range(0, 19);
                r_ren  = (kind >= 12);
                r_wen  = (kind >= 5 && kind <= 11) || (kind >= 18);
                r_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
                         | 32'($urandom_range(0, 3));
                r_data = $urandom;
            end
            g = ($urandom_range(0, 9) < 6);
            step(0, r_ren, r_wen, r_addr, r_data, g);

            t = r_addr[11:2];
            miss = 0; accept = 0; exp_stall = 0; exp_rdata = 0;
            dpos = (mq.size() > 0);
            if (rd_wait_m) begin
                exp_rdata = rd_val;
            end else if (r_wen) begin
                accept    = (mq.size() < SB_DEPTH) || (dpos && g);
                exp_stall = !accept;
            end else if (r_ren) begin
                hit = 0;
                foreach (mq[j]) if (mq[j].tag == t) hit = 1;
                if (hit) begin
                    exp_rdata = arch_mem[t];
                end else begin
                    miss      = 1;
                    exp_stall = 1;
                    dpos      = 0;
                end
            end
            chk($sformatf("r%0d stall", c), 32'(cpu_bus.mem_stall), 32'(exp_stall));
            chk($sformatf("r%0d rdata", c), cpu_bus.mem_rdata, exp_rdata);
            chk($sformatf("r%0d req", c), 32'(ram_bus.ram_req), 32'(miss || dpos));
            chk($sformatf("r%0d we", c), 32'(ram_bus.ram_we), 32'(dpos));
            chk($sformatf("r%0d count", c), 32'(sb_count), 32'(mq.size()));
            if (miss) begin
                chk($sformatf("r%0d rdaddr", c), 32'(ram_bus.ram_addr), 32'(t));
            end else if (dpos) begin
                chk($sformatf("r%0d draddr", c), 32'(ram_bus.ram_addr), 32'(mq[0].tag));
                chk($sformatf("r%0d drdata", c), ram_bus.ram_wdata, mq[0].data);
            end

            if (dpos && g) void'(mq.pop_front());
            if (accept) begin
                mq.push_back('{t, r_data});
                arch_mem[t] = r_data;
            end
            rd_wait_m = miss && g;
            if (rd_wait_m) rd_val = arch_mem[t];
            hold = exp_stall;
        end

        n = 0;
        while (!sb_empty && n < 20) begin
            step(0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("final drain", 32'(sb_empty), 32'h1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("final ram%0d", i), ram_mem[i], arch_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
